// File: rtl/ascii_serial_rx.sv
// -----------------------------------------------------------------------------
// ascii_serial_rx
//
// Front-end receiver for the ASCII-to-Braille decoder. Accepts 8N1
// asynchronous serial characters (LSB first, line idles high) and holds the
// low six bits of the most recent good character on the decoder inputs c..h
// until the next good character arrives.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (>= 4)
//   SYNC_STAGES   flip-flop stages in the rx synchronizer (>= 2)
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset, synchronous release expected
//   rx         serial line input
//   c..h       held character bits 5..0 (h is the LSB)
//   char_out   full held byte, for debug/display
//   valid      one-cycle pulse when the held register updates
//   frame_err  one-cycle pulse when a frame ends with a low stop bit
//   busy       high while a frame is being received
// -----------------------------------------------------------------------------
module ascii_serial_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       f,
  output logic       g,
  output logic       h,
  output logic [7:0] char_out,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  // Terminal counts for the baud counter. The counter runs 0..LAST, so a
  // wait of N cycles terminates when the counter reaches N-1.
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'((CLKS_PER_BIT / 2) - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizer
  // ---------------------------------------------------------------------------
  // The stages reset to 1 so that the idle-high line does not look like a
  // start edge when reset is released.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic                   rx_prev;

  // NOTE: sequential state is always written with non-blocking assignments so
  // that every flop samples the values from before the clock edge; a blocking
  // assignment here would collapse the synchronizer chain into one stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '1;
      rx_prev <= 1'b1;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], rx};
      rx_prev <= rx_s;
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  // A start edge needs the line to have been seen high in the previous
  // cycle. This is what keeps a line held low after a bad stop bit (break)
  // from immediately starting another frame.
  logic fall_edge;
  assign fall_edge = rx_prev & ~rx_s;

  // ---------------------------------------------------------------------------
  // Receive FSM, baud counter, shift register and held character
  // ---------------------------------------------------------------------------
  state_t           state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic [7:0]       char_q;
  logic             valid_q;
  logic             ferr_q;

  logic             baud_half_done;
  logic             baud_full_done;

  assign baud_half_done = (baud_cnt == HALF_LAST);
  assign baud_full_done = (baud_cnt == FULL_LAST);

  // NOTE: the shift register and held character are small registers, not a
  // memory, so they take the same asynchronous reset as the control state;
  // this guarantees char_out reads 0 immediately when reset is asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      char_q   <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      // NOTE: the status pulses default low every cycle and are only raised
      // in the single cycle that needs them, which makes them exactly one
      // clock wide without any separate clearing logic.
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;

      case (state)
        IDLE: begin
          baud_cnt <= '0;
          bit_idx  <= '0;
          if (fall_edge) begin
            state <= START;
          end
        end

        // Wait half a bit so that every later sample lands mid-bit, then
        // confirm the start bit is still low. A high line here was a glitch.
        START: begin
          if (baud_half_done) begin
            baud_cnt <= '0;
            if (!rx_s) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        // One sample per full bit period, assembled LSB first.
        DATA: begin
          if (baud_full_done) begin
            baud_cnt       <= '0;
            shreg[bit_idx] <= rx_s;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        // A good stop bit commits the byte; a bad one only flags the error
        // and leaves the previously held character in place.
        STOP: begin
          if (baud_full_done) begin
            baud_cnt <= '0;
            state    <= IDLE;
            if (rx_s) begin
              char_q  <= shreg;
              valid_q <= 1'b1;
            end else begin
              ferr_q <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        default: begin
          state    <= IDLE;
          baud_cnt <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // All outputs are direct decodes of registers, so they are glitch-free and
  // change only on clock edges (or on asynchronous reset).
  assign char_out  = char_q;
  assign {c, d, e, f, g, h} = char_q[5:0];
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_ascii_serial_rx.sv
// -----------------------------------------------------------------------------
// tb_ascii_serial_rx
//
// Self-checking bench for ascii_serial_rx with CLKS_PER_BIT = 8 and
// SYNC_STAGES = 2. Frames are built bit by bit from the 8N1 rules; the
// expected held character, pulse counts and edge-to-valid latency come from
// a simple model of what a receiver must report for each frame sent.
// -----------------------------------------------------------------------------
module tb_ascii_serial_rx;

  localparam int CPB  = 8;
  localparam int SYNC = 2;
  localparam int LAT  = SYNC + CPB / 2 + 9 * CPB + 1;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic       c, d, e, f, g, h;
  logic [7:0] char_out;
  logic       valid;
  logic       frame_err;
  logic       busy;
  logic [5:0] cdefgh;

  assign cdefgh = {c, d, e, f, g, h};

  ascii_serial_rx #(
    .CLKS_PER_BIT(CPB),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .c        (c),
    .d        (d),
    .e        (e),
    .f        (f),
    .g        (g),
    .h        (h),
    .char_out (char_out),
    .valid    (valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Pulse bookkeeping, sampled mid-cycle.
  int   valid_cnt      = 0;
  int   ferr_cnt       = 0;
  int   last_valid_cyc = 0;
  int   fall_cyc       = 0;
  logic prev_valid     = 1'b0;
  logic prev_ferr      = 1'b0;

  // Model of the held character.
  logic [7:0] exp_char = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (valid || frame_err) begin
      chk("valid_and_frame_err_exclusive", 32'(valid && frame_err), 32'd0);
    end
    if (valid) begin
      valid_cnt++;
      last_valid_cyc = cyc;
      chk("valid_single_cycle", 32'(prev_valid), 32'd0);
    end
    if (frame_err) begin
      ferr_cnt++;
      chk("frame_err_single_cycle", 32'(prev_ferr), 32'd0);
    end
    prev_valid = valid;
    prev_ferr  = frame_err;
  end

  // Drive one 8N1 frame: start bit 0, data LSB first, then the stop bit.
  // abort_at >= 0 returns early at that cycle of the frame without driving.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int abort_at);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10 * CPB; i++) begin
      @(negedge clk);
      if (i == abort_at) return;
      rx = bits[i / CPB];
      if (i == 0) fall_cyc = cyc;
    end
    #1;
  endtask

  task automatic idle_cycles(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Send a frame and compare every observable against the model.
  task automatic frame_check(input string tag, input logic [7:0] b, input logic stop);
    int v0, f0, lat;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    send_frame(b, stop, -1);
    if (stop) exp_char = b;
    chk($sformatf("%s_valid_count", tag), 32'(valid_cnt - v0), stop ? 32'd1 : 32'd0);
    chk($sformatf("%s_frame_err_count", tag), 32'(ferr_cnt - f0), stop ? 32'd0 : 32'd1);
    chk($sformatf("%s_char_out", tag), 32'(char_out), 32'(exp_char));
    chk($sformatf("%s_cdefgh", tag), 32'(cdefgh), 32'(exp_char[5:0]));
    if (stop) begin
      lat = last_valid_cyc - fall_cyc;
      chk($sformatf("%s_latency_%0d", tag, lat), 32'(lat >= LAT - 1 && lat <= LAT + 1), 32'd1);
    end
  endtask

  initial begin
    logic [7:0] rb;
    logic       rstop;
    int         gap;
    int         v0, f0;
    logic       busy_seen;

    // ---- Reset state --------------------------------------------------------
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_char_out", 32'(char_out), 32'h00);
    chk("reset_cdefgh", 32'(cdefgh), 32'h00);
    chk("reset_valid", 32'(valid), 32'd0);
    chk("reset_frame_err", 32'(frame_err), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    idle_cycles(5);

    // ---- First frame: 'A' ---------------------------------------------------
    frame_check("char_A", 8'h41, 1'b1);
    chk("char_A_bits", 32'(cdefgh), 32'(6'b000001));
    idle_cycles(4);

    // ---- Back-to-back 'a' then 'z' with no idle gap -------------------------
    frame_check("char_a", 8'h61, 1'b1);
    chk("char_a_bits", 32'(cdefgh), 32'(6'b100001));
    frame_check("char_z", 8'h7A, 1'b1);
    chk("char_z_bits", 32'(cdefgh), 32'(6'b111010));
    idle_cycles(4);

    // ---- Start glitch shorter than half a bit -------------------------------
    v0 = valid_cnt;
    f0 = ferr_cnt;
    busy_seen = 1'b0;
    @(negedge clk); rx = 1'b0;
    @(negedge clk); rx = 1'b0;
    @(negedge clk); rx = 1'b1;
    for (int i = 0; i < 2 * CPB; i++) begin
      @(negedge clk);
      if (busy) busy_seen = 1'b1;
    end
    chk("glitch_busy_rose", 32'(busy_seen), 32'd1);
    chk("glitch_busy_fell", 32'(busy), 32'd0);
    chk("glitch_no_valid", 32'(valid_cnt - v0), 32'd0);
    chk("glitch_no_frame_err", 32'(ferr_cnt - f0), 32'd0);
    chk("glitch_char_unchanged", 32'(char_out), 32'(exp_char));

    // ---- Bad stop after 'A', then break (line held low) ---------------------
    frame_check("pre_bad_A", 8'h41, 1'b1);
    frame_check("bad_stop_55", 8'h55, 1'b0);
    chk("bad_stop_keeps_41", 32'(char_out), 32'h41);
    v0 = valid_cnt;
    f0 = ferr_cnt;
    busy_seen = 1'b0;
    rx = 1'b0;
    for (int i = 0; i < 4 * CPB; i++) begin
      @(negedge clk);
      if (busy) busy_seen = 1'b1;
    end
    chk("break_no_frame", 32'(busy_seen), 32'd0);
    idle_cycles(6);
    chk("break_release_idle", 32'(busy), 32'd0);
    chk("break_no_pulses", 32'(valid_cnt - v0 + ferr_cnt - f0), 32'd0);
    frame_check("after_break_K", 8'h4B, 1'b1);
    idle_cycles(3);

    // ---- Reset during data bit 4 of 8'hFF -----------------------------------
    send_frame(8'hFF, 1'b1, 5 * CPB + CPB / 2);
    chk("midframe_busy_before_reset", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    exp_char = 8'h00;
    chk("midframe_reset_busy", 32'(busy), 32'd0);
    chk("midframe_reset_char_out", 32'(char_out), 32'h00);
    chk("midframe_reset_cdefgh", 32'(cdefgh), 32'h00);
    chk("midframe_reset_valid", 32'(valid), 32'd0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(5);
    frame_check("after_reset_30", 8'h30, 1'b1);
    chk("after_reset_30_bits", 32'(cdefgh), 32'(6'b110000));
    idle_cycles(3);

    // ---- Latency and bit order ----------------------------------------------
    frame_check("lat_00", 8'h00, 1'b1);
    idle_cycles(2);
    frame_check("lat_80", 8'h80, 1'b1);
    idle_cycles(2);
    frame_check("lat_01", 8'h01, 1'b1);
    idle_cycles(2);

    // ---- Randomized frames, mixed good/bad stop bits and gaps ---------------
    for (int n = 0; n < 12; n++) begin
      rb    = 8'($urandom);
      rstop = ($urandom_range(0, 3) != 0);
      frame_check($sformatf("rand%0d_%02h_s%0d", n, rb, rstop), rb, rstop);
      // After a low stop bit the line must go high again before a new start.
      gap = rstop ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 3));
      rx = 1'b1;
      repeat (gap) @(negedge clk);
    end
    idle_cycles(2 * CPB);
    chk("final_idle_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ascii_serial_rx.md
Name: ascii_serial_rx

Overview:
- Upstream front-end for the ASCII-to-Braille decoder.
- Receives 8N1 asynchronous serial ASCII characters on one line.
- Holds the low six bits of the last good character on the decoder's six character inputs c..h until the next good character arrives.
- Provides valid, error and busy status for the top level.

Parameters:
CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200 baud); legal range >= 4
SYNC_STAGES, 2, flip-flop stages in the rx input synchronizer; legal range >= 2

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
rx  input  1  serial line; idles high; LSB first
c  output  1  held character bit 5 (to decoder input c)
d  output  1  held character bit 4
e  output  1  held character bit 3
f  output  1  held character bit 2
g  output  1  held character bit 1
h  output  1  held character bit 0 (LSB)
char_out  output  8  full held byte, for debug/display
valid  output  1  one-cycle pulse when the held register updates
frame_err  output  1  one-cycle pulse on a bad stop bit
busy  output  1  high while a frame is being received (any state other than IDLE)

Behaviour:
- Reset (async assert, sync release):
  - synchronizer stages = 1, state = IDLE, counters = 0.
  - char_out = 8'h00, so c..h = 0.
  - valid = 0, frame_err = 0, busy = 0.
- Synchronizer: rx passes through SYNC_STAGES flops; rx_s is the last stage. All decisions use rx_s only.
- Bit counter: baud counter counts 0..CLKS_PER_BIT-1; the bit index is 3 bits.
- IDLE:
  - A falling edge is rx_s = 0 while the previous rx_s = 1.
  - On a falling edge: go to START and load the baud counter for a half-bit wait of CLKS_PER_BIT/2 (integer division).
- START:
  - At the end of the half-bit wait, sample rx_s.
  - 0: go to DATA, bit index = 0, full-bit wait.
  - 1: glitch; return to IDLE with no pulse and no register change.
- DATA:
  - After each full-bit wait, shift rx_s into bit[index], LSB first.
  - After index 7 is sampled, go to STOP with a full-bit wait.
- STOP: after the full-bit wait, sample rx_s.
  - 1: char_out <= shift register; valid = 1 for exactly one cycle (the cycle after the sample edge).
  - 0: frame_err = 1 for one cycle; char_out is unchanged.
  - In both cases return to IDLE.
- Break condition: a line held low after a STOP error does not start a new frame. IDLE requires rx_s to be seen high before a new falling edge is accepted.
- Output mapping: {c,d,e,f,g,h} = char_out[5:0]. Bits 7:6 are carried only on char_out. c..h change only on the valid cycle.
- Latency: valid asserts SYNC_STAGES + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles (±1) after the start-bit falling edge on rx.
- Back-to-back frames: a start edge arriving in the cycle right after the STOP sample is accepted, with no dead time beyond the return to IDLE.
- valid and frame_err are never high in the same cycle.
- Reset mid-frame: the frame is discarded and all outputs return to their reset values immediately.

Test Plan:
- Reset → frame: with CLKS_PER_BIT=8, drive an 8N1 frame for 'A' (8'h41). Required: one valid pulse; char_out = 8'h41; {c..h} = 6'b000001; frame_err stays 0.
- Back-to-back: send 'a' (8'h61) then 'z' (8'h7A) with no idle gap. Required: two valid pulses; after the first, {c..h} = 6'b100001; after the second, {c..h} = 6'b111010.
- Start glitch: hold rx low for 2 cycles (< CLKS_PER_BIT/2), then high. Required: busy rises then falls; no valid; no frame_err; char_out unchanged.
- Bad stop: send 8'h55 with stop bit = 0, after 'A' was received. Required: one frame_err pulse; no valid; char_out stays 8'h41. With the line then held low, no new frame starts until rx returns high.
- Reset mid-frame: assert rst_n low during data bit 4 of 8'hFF. Required: busy = 0 and char_out = 0 immediately. The next full frame 8'h30 is received correctly, giving {c..h} = 6'b110000.
- Latency/bit order check: for each byte 8'h00, 8'h80 and 8'h01, measure the edge-to-valid delay against the formula within ±1 cycle, and check LSB-first assembly.
